// File: rtl/matrix_out_if.sv
// matrix_out_if: valid/ready element stream carrying one matrix element per beat
//   m_data  element value        m_valid  beat valid
//   m_ready sink accepts beat    m_last   final element of the frame
//   m_index element index row*N+col
interface matrix_out_if #(
    parameter int ELEM_W = 8
) ();
    logic [ELEM_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic [3:0]        m_index;
    modport master (output m_data, m_valid, m_last, m_index, input m_ready);
    modport slave (input m_data, m_valid, m_last, m_index, output m_ready);
endinterface

// File: rtl/matrix_out_unloader.sv
// matrix_out_unloader: captures the inverter result on a rising done edge and streams it row-major
//   clk, rst   clock, synchronous active-high reset
//   done_in    inverter done level; only a 0->1 transition starts a frame
//   matrix_in  packed result, element e at [e*ELEM_W +: ELEM_W]
//   m          element stream (master side)
//   busy       frame in flight
//   overflow   sticky: a done edge arrived mid-frame and was dropped; ovf_clr clears it
//   frame_cnt  completed frames, wraps
module matrix_out_unloader #(
    parameter int N      = 3,
    parameter int ELEM_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    done_in,
    input  logic [N*N*ELEM_W-1:0]   matrix_in,
    matrix_out_if.master            m,
    output logic                    busy,
    output logic                    overflow,
    input  logic                    ovf_clr,
    output logic [7:0]              frame_cnt
);
    localparam logic [3:0] LAST = 4'(N*N-1);
    typedef enum logic {IDLE, SEND} state_t;
    state_t            state, state_d;
    logic [3:0]        idx, idx_d;
    logic [ELEM_W-1:0] sh [N*N];
    logic              done_q, ev, hs, fin, cap, ovf_set;
    assign ev  = done_in & ~done_q;
    assign hs  = (state == SEND) & m.m_ready;
    assign fin = hs & (idx == LAST);
    // A new frame is accepted when idle or exactly on the final handshake (back-to-back).
    always_comb begin
        cap     = ev & ((state == IDLE) | fin);
        ovf_set = ev & (state == SEND) & ~fin;
        state_d = cap ? SEND : fin ? IDLE : state;
        idx_d   = (cap | fin) ? 4'd0 : hs ? idx + 4'd1 : idx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 4'd0;
            done_q    <= 1'b0;
            overflow  <= 1'b0;
            frame_cnt <= 8'd0;
            for (int e = 0; e < N*N; e++) sh[e] <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            done_q    <= done_in;
            overflow  <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : overflow;
            frame_cnt <= frame_cnt + {7'd0, fin};
            if (cap)
                for (int e = 0; e < N*N; e++) sh[e] <= matrix_in[e*ELEM_W +: ELEM_W];
        end
    end
    assign busy      = state == SEND;
    assign m.m_valid = busy;
    assign m.m_data  = sh[idx];
    assign m.m_index = idx;
    assign m.m_last  = busy & (idx == LAST);
endmodule

// File: tb/tb_matrix_out_unloader.sv
// tb_matrix_out_unloader: directed scenarios for the matrix stream unloader
module tb_matrix_out_unloader;
    localparam logic [71:0] MA = 72'h06_05_03_05_01_02_03_02_01;
    localparam logic [71:0] MB = 72'h01_02_03_04_05_06_07_08_09;
    localparam logic [71:0] MX = {9{8'hAA}};
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done_in = 1'b0;
    logic [71:0] matrix_in = '0;
    logic        busy, overflow;
    logic        ovf_clr = 1'b0;
    logic [7:0]  frame_cnt;
    logic [7:0]  ea [9] = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd5, 8'd3, 8'd5, 8'd6};
    int          passed = 0;
    int          total = 0;

    matrix_out_if #(.ELEM_W(8)) bus ();

    matrix_out_unloader #(.N(3), .ELEM_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .matrix_in (matrix_in),
        .m         (bus),
        .busy      (busy),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [71:0] mat);
        matrix_in = mat;
        done_in   = 1'b1;
        tick();
        done_in   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus.m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.m_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else passed++;
        total++; if (frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else passed++;
        total++; if ({bus.m_last, bus.m_index, bus.m_data} !== 13'd0)
            $display("FAIL reset_stream: got %h want 0", {bus.m_last, bus.m_index, bus.m_data}); else passed++;
    endtask

    task automatic test_basic();
        logic [14:0] got, exp;
        bus.m_ready = 1'b1;
        start(MA);
        for (int k = 0; k < 9; k++) begin
            got = {bus.m_valid, bus.m_index, bus.m_data, bus.m_last, busy};
            exp = {1'b1, 4'(k), ea[k], k == 8, 1'b1};
            total++; if (got !== exp) $display("FAIL basic_beat%0d: got %h want %h", k, got, exp); else passed++;
            tick();
        end
        total++; if ({bus.m_valid, busy} !== 2'b00) $display("FAIL basic_end_idle: got %b want 00", {bus.m_valid, busy}); else passed++;
        total++; if (frame_cnt !== 8'd1) $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); else passed++;
    endtask

    task automatic test_backpressure();
        int k = 0, stall = 0, held = 0;
        logic [12:0] got, exp;
        start(MA);
        for (int c = 0; c < 30 && k < 9; c++) begin
            got = {bus.m_valid, bus.m_index, bus.m_data};
            exp = {1'b1, 4'(k), ea[k]};
            total++; if (got !== exp) $display("FAIL bp_cycle%0d: got %h want %h", c, got, exp); else passed++;
            if (k == 4) held++;
            bus.m_ready = !(k == 4 && stall < 3);
            if (!bus.m_ready) stall++;
            else k++;
            tick();
        end
        bus.m_ready = 1'b1;
        total++; if (k !== 9) $display("FAIL bp_beats: got %0d want 9", k); else passed++;
        total++; if (held !== 4) $display("FAIL bp_hold_cycles: got %0d want 4", held); else passed++;
        total++; if (bus.m_valid !== 1'b0) $display("FAIL bp_end_valid: got %b want 0", bus.m_valid); else passed++;
        total++; if (frame_cnt !== 8'd2) $display("FAIL bp_frame_cnt: got %0d want 2", frame_cnt); else passed++;
    endtask

    task automatic test_overflow();
        logic [12:0] got, exp;
        start(MA);
        for (int k = 0; k < 9; k++) begin
            got = {bus.m_valid, bus.m_index, bus.m_data};
            exp = {1'b1, 4'(k), ea[k]};
            total++; if (got !== exp) $display("FAIL ovf_beat%0d: got %h want %h", k, got, exp); else passed++;
            if (k == 2) begin
                matrix_in = MX;
                done_in = 1'b1;
            end
            tick();
            done_in = 1'b0;
        end
        total++; if (frame_cnt !== 8'd3) $display("FAIL ovf_frame_cnt: got %0d want 3", frame_cnt); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else passed++;
        tick(); tick(); tick();
        total++; if ({bus.m_valid, overflow} !== 2'b01) $display("FAIL ovf_sticky: got %b want 01", {bus.m_valid, overflow}); else passed++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else passed++;
        start(MA);
        tick();
        done_in = 1'b1;
        ovf_clr = 1'b1;
        tick();
        done_in = 1'b0;
        ovf_clr = 1'b0;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", overflow); else passed++;
        for (int c = 0; c < 20 && bus.m_valid; c++) tick();
        total++; if ({bus.m_valid, frame_cnt} !== {1'b0, 8'd4}) $display("FAIL ovf_second_frame: got %h want 004", {bus.m_valid, frame_cnt}); else passed++;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [12:0] got, exp;
        start(MA);
        for (int k = 0; k < 9; k++) begin
            got = {bus.m_valid, bus.m_index, bus.m_data};
            exp = {1'b1, 4'(k), ea[k]};
            total++; if (got !== exp) $display("FAIL b2b_a_beat%0d: got %h want %h", k, got, exp); else passed++;
            if (k == 8) begin
                matrix_in = MB;
                done_in = 1'b1;
            end
            tick();
            done_in = 1'b0;
        end
        total++; if ({overflow, frame_cnt} !== {1'b0, 8'd5}) $display("FAIL b2b_join: got %h want 005", {overflow, frame_cnt}); else passed++;
        for (int k = 0; k < 9; k++) begin
            got = {bus.m_valid, bus.m_index, bus.m_data};
            exp = {1'b1, 4'(k), 8'(9 - k)};
            total++; if (got !== exp) $display("FAIL b2b_b_beat%0d: got %h want %h", k, got, exp); else passed++;
            tick();
        end
        total++; if ({bus.m_valid, frame_cnt} !== {1'b0, 8'd6}) $display("FAIL b2b_end: got %h want 006", {bus.m_valid, frame_cnt}); else passed++;
    endtask

    task automatic test_level();
        int beats = 0;
        rst = 1'b1;
        matrix_in = MA;
        done_in = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        total++; if ({bus.m_valid, bus.m_index} !== 5'b1_0000) $display("FAIL level_first_after_reset: got %b want 10000", {bus.m_valid, bus.m_index}); else passed++;
        for (int c = 0; c < 30; c++) begin
            if (bus.m_valid) beats++;
            tick();
        end
        done_in = 1'b0;
        tick();
        total++; if (beats !== 9) $display("FAIL level_beats: got %0d want 9", beats); else passed++;
        total++; if ({bus.m_valid, frame_cnt} !== {1'b0, 8'd1}) $display("FAIL level_frames: got %h want 001", {bus.m_valid, frame_cnt}); else passed++;
    endtask

    task automatic test_reset_mid();
        start(MA);
        for (int c = 0; c < 5; c++) tick();
        total++; if (bus.m_index !== 4'd5) $display("FAIL rstmid_index: got %0d want 5", bus.m_index); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({bus.m_valid, busy, bus.m_index, frame_cnt} !== 14'd0)
            $display("FAIL rstmid_state: got %h want 0", {bus.m_valid, busy, bus.m_index, frame_cnt}); else passed++;
        tick();
        total++; if (bus.m_valid !== 1'b0) $display("FAIL rstmid_no_restart: got %b want 0", bus.m_valid); else passed++;
        start(MB);
        total++; if ({bus.m_valid, bus.m_index, bus.m_data} !== {1'b1, 4'd0, 8'd9})
            $display("FAIL rstmid_fresh: got %h want 1009", {bus.m_valid, bus.m_index, bus.m_data}); else passed++;
        for (int c = 0; c < 20 && bus.m_valid; c++) tick();
        total++; if (frame_cnt !== 8'd1) $display("FAIL rstmid_frame_cnt: got %0d want 1", frame_cnt); else passed++;
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_level();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
